// File: rtl/seq_det_pkg.sv
// Shared constants, helper function and beat classification for the parametrised sequence detector.
package seq_det_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned SEQ_LEN_DEF = 3;
    localparam int unsigned CNT_W_DEF   = 8;
    localparam int unsigned TIMEOUT_DEF = 16;

    localparam logic [CNT_W_DEF-1:0] HIT_CNT_SAT_DEF = {CNT_W_DEF{1'b1}};

    // Outcome of one cycle seen from the progress register's point of view
    typedef enum logic [2:0] {
        BEAT_NONE    = 3'd0,
        BEAT_ADV     = 3'd1,
        BEAT_DONE    = 3'd2,
        BEAT_RESTART = 3'd3,
        BEAT_DROP    = 3'd4
    } beat_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        if (n <= 32'd1) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Stream, pattern and result bundle between a stimulus source (master) and the detector (slave).
interface seq_detector_param_if
    import seq_det_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SEQ_LEN = SEQ_LEN_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) ();

    localparam int unsigned PROG_W = clog2_min1(SEQ_LEN);

    logic                        in_valid;
    logic [DATA_W-1:0]           in_data;
    logic [SEQ_LEN*DATA_W-1:0]   pattern;
    logic                        clr;
    logic                        match;
    logic                        found;
    logic [CNT_W-1:0]            hit_cnt;
    logic [PROG_W-1:0]           progress;

    modport master (
        output in_valid, in_data, pattern, clr,
        input  match, found, hit_cnt, progress
    );

    modport slave (
        input  in_valid, in_data, pattern, clr,
        output match, found, hit_cnt, progress
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; clear wins over increment, and the count never wraps.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] SAT_MAX = {W{1'b1}};

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != SAT_MAX)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Programmable non-overlapping sequence detector: match pulse, sticky found flag, saturating hit count.
// Optional build macro SEQ_DET_TIMEOUT_EN drops partial progress after TIMEOUT idle cycles.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SEQ_LEN = SEQ_LEN_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_detector_param_if.slave   bus
);

    localparam int unsigned PROG_W = clog2_min1(SEQ_LEN);
    localparam logic [PROG_W-1:0] LAST = PROG_W'(SEQ_LEN - 1);

`ifdef SEQ_DET_TIMEOUT_EN
    localparam bit TIMEOUT_USED = 1'b1;
`else
    localparam bit TIMEOUT_USED = 1'b0;
`endif

    if ((SEQ_LEN < 1) || (TIMEOUT_USED && (TIMEOUT < 1))) begin : g_cfg_check
        $error("seq_detector_param: SEQ_LEN and TIMEOUT must be at least 1");
    end

    logic [PROG_W-1:0] r_progress;
    logic              r_match;
    logic              r_found;
    logic [PROG_W-1:0] w_progress_nxt;
    logic              w_match_nxt;
    logic              w_hit;
    logic              w_timeout;
    logic [DATA_W-1:0] w_sym_cur;
    logic [DATA_W-1:0] w_sym_first;
    beat_e             w_beat;

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int unsigned IDLE_W = clog2_min1(TIMEOUT + 1);

    logic [IDLE_W-1:0] w_idle_cnt;
    logic              w_idle_inc;

    // Counts idle cycles only while a partial sequence is held
    assign w_idle_inc = !bus.in_valid && (r_progress != '0);
    assign w_timeout  = w_idle_inc && (w_idle_cnt == IDLE_W'(TIMEOUT - 1));

    sat_counter #(.W(IDLE_W)) u_idle_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_idle_inc),
        .i_clr (!w_idle_inc),
        .o_cnt (w_idle_cnt)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and beat classification
    always_comb begin
        w_sym_first    = bus.pattern[0 +: DATA_W];
        w_sym_cur      = bus.pattern[0 +: DATA_W];
        w_beat         = BEAT_NONE;
        w_progress_nxt = r_progress;
        w_match_nxt    = 1'b0;

        for (int k = 0; k < SEQ_LEN; k++) begin
            if (r_progress == PROG_W'(k)) w_sym_cur = bus.pattern[k*DATA_W +: DATA_W];
        end

        if (bus.in_valid) begin
            if (bus.in_data == w_sym_cur) begin
                if (r_progress == LAST) begin
                    w_beat         = BEAT_DONE;
                    w_progress_nxt = '0;
                    w_match_nxt    = 1'b1;
                end else begin
                    w_beat         = BEAT_ADV;
                    w_progress_nxt = r_progress + PROG_W'(1);
                end
            end else if (bus.in_data == w_sym_first) begin
                // Only reachable with SEQ_LEN > 1, so progress 1 is in range
                w_beat         = BEAT_RESTART;
                w_progress_nxt = PROG_W'(1);
            end else begin
                w_beat         = BEAT_DROP;
                w_progress_nxt = '0;
            end
        end else if (w_timeout) begin
            w_progress_nxt = '0;
        end
    end

    assign w_hit = (w_beat == BEAT_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_progress <= '0;
            r_match    <= 1'b0;
            r_found    <= 1'b0;
        end else begin
            r_progress <= w_progress_nxt;
            r_match    <= w_match_nxt;
            if (bus.clr) begin
                r_found <= 1'b0;
            end else if (w_hit) begin
                r_found <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_hit),
        .i_clr (bus.clr),
        .o_cnt (bus.hit_cnt)
    );

    assign bus.match    = r_match;
    assign bus.found    = r_found;
    assign bus.progress = r_progress;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default, CNT_W=2 and SEQ_LEN=1 instances on one clock.
module tb_seq_detector_param;

`ifdef SEQ_DET_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_hit_a = 0;

    always #5 clk = ~clk;

    seq_detector_param_if #(.DATA_W(8), .SEQ_LEN(3), .CNT_W(8)) if_a ();
    seq_detector_param_if #(.DATA_W(8), .SEQ_LEN(3), .CNT_W(2)) if_b ();
    seq_detector_param_if #(.DATA_W(8), .SEQ_LEN(1), .CNT_W(8)) if_c ();

    seq_detector_param #(.DATA_W(8), .SEQ_LEN(3), .CNT_W(8), .TIMEOUT(4)) u_dut_a (
        .clk(clk), .rst(rst), .bus(if_a));
    seq_detector_param #(.DATA_W(8), .SEQ_LEN(3), .CNT_W(2), .TIMEOUT(4)) u_dut_b (
        .clk(clk), .rst(rst), .bus(if_b));
    seq_detector_param #(.DATA_W(8), .SEQ_LEN(1), .CNT_W(8), .TIMEOUT(4)) u_dut_c (
        .clk(clk), .rst(rst), .bus(if_c));

    task automatic step_a(input logic v, input logic [7:0] d);
        if_a.in_valid = v; if_a.in_data = d;
        @(posedge clk); #1;
    endtask

    task automatic step_b(input logic v, input logic [7:0] d);
        if_b.in_valid = v; if_b.in_data = d;
        @(posedge clk); #1;
    endtask

    task automatic step_c(input logic v, input logic [7:0] d);
        if_c.in_valid = v; if_c.in_data = d;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.clr = 1'b0; if_a.pattern = 24'h6ef526;
        if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.clr = 1'b0; if_b.pattern = 24'h6ef526;
        if_c.in_valid = 1'b0; if_c.in_data = '0; if_c.clr = 1'b0; if_c.pattern = 8'ha5;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (if_a.progress !== 2'd0) begin errors++; $display("FAIL reset_progress: got %0d want 0", if_a.progress); end
        checks++; if (if_a.match !== 1'b0)    begin errors++; $display("FAIL reset_match: got %b want 0", if_a.match); end
        checks++; if (if_a.found !== 1'b0)    begin errors++; $display("FAIL reset_found: got %b want 0", if_a.found); end
        checks++; if (if_a.hit_cnt !== 8'd0)  begin errors++; $display("FAIL reset_hit: got %0d want 0", if_a.hit_cnt); end
        checks++; if (if_b.hit_cnt !== 2'd0)  begin errors++; $display("FAIL reset_hit_b: got %0d want 0", if_b.hit_cnt); end
        checks++; if (if_c.match !== 1'b0)    begin errors++; $display("FAIL reset_match_c: got %b want 0", if_c.match); end
    endtask

    task automatic test_basic();
        logic [7:0] d   [3] = '{8'h26, 8'hf5, 8'h6e};
        logic [1:0] e_p [3] = '{2'd1, 2'd2, 2'd0};
        logic       e_m [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, d[i]);
            checks++; if (if_a.progress !== e_p[i]) begin errors++; $display("FAIL basic_progress[%0d]: got %0d want %0d", i, if_a.progress, e_p[i]); end
            checks++; if (if_a.match !== e_m[i])    begin errors++; $display("FAIL basic_match[%0d]: got %b want %b", i, if_a.match, e_m[i]); end
        end
        exp_hit_a = 1;
        checks++; if (if_a.found !== 1'b1)   begin errors++; $display("FAIL basic_found: got %b want 1", if_a.found); end
        checks++; if (if_a.hit_cnt !== 8'd1) begin errors++; $display("FAIL basic_hit: got %0d want 1", if_a.hit_cnt); end
        step_a(1'b0, 8'h00);
        checks++; if (if_a.match !== 1'b0)   begin errors++; $display("FAIL basic_match_drop: got %b want 0", if_a.match); end
    endtask

    task automatic test_restart();
        logic [7:0] d1  [4] = '{8'h26, 8'h26, 8'hf5, 8'h6e};
        logic [1:0] p1  [4] = '{2'd1, 2'd1, 2'd2, 2'd0};
        logic       m1  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] d2  [4] = '{8'h26, 8'hf5, 8'h00, 8'h6e};
        logic [1:0] p2  [4] = '{2'd1, 2'd2, 2'd0, 2'd0};
        for (int i = 0; i < 4; i++) begin
            step_a(1'b1, d1[i]);
            checks++; if (if_a.progress !== p1[i]) begin errors++; $display("FAIL restart_progress[%0d]: got %0d want %0d", i, if_a.progress, p1[i]); end
            checks++; if (if_a.match !== m1[i])    begin errors++; $display("FAIL restart_match[%0d]: got %b want %b", i, if_a.match, m1[i]); end
        end
        exp_hit_a++;
        for (int i = 0; i < 4; i++) begin
            step_a(1'b1, d2[i]);
            checks++; if (if_a.progress !== p2[i]) begin errors++; $display("FAIL break_progress[%0d]: got %0d want %0d", i, if_a.progress, p2[i]); end
            checks++; if (if_a.match !== 1'b0)     begin errors++; $display("FAIL break_match[%0d]: got %b want 0", i, if_a.match); end
        end
        checks++; if (if_a.hit_cnt !== 8'(exp_hit_a)) begin errors++; $display("FAIL restart_hit: got %0d want %0d", if_a.hit_cnt, exp_hit_a); end
    endtask

    task automatic test_idle();
        logic [1:0] e_p;
        step_a(1'b1, 8'h26);
        for (int i = 1; i <= 5; i++) begin
            step_a(1'b0, 8'h00);
            e_p = (TO_EN && (i >= 4)) ? 2'd0 : 2'd1;
            checks++; if (if_a.progress !== e_p) begin errors++; $display("FAIL idle_progress[%0d]: got %0d want %0d", i, if_a.progress, e_p); end
            checks++; if (if_a.match !== 1'b0)   begin errors++; $display("FAIL idle_match[%0d]: got %b want 0", i, if_a.match); end
        end
        step_a(1'b1, 8'hf5);
        e_p = TO_EN ? 2'd0 : 2'd2;
        checks++; if (if_a.progress !== e_p) begin errors++; $display("FAIL idle_resume: got %0d want %0d", if_a.progress, e_p); end
        step_a(1'b1, 8'h6e);
        checks++; if (if_a.match !== !TO_EN) begin errors++; $display("FAIL idle_match_end: got %b want %b", if_a.match, !TO_EN); end
        exp_hit_a += TO_EN ? 0 : 1;
        checks++; if (if_a.hit_cnt !== 8'(exp_hit_a)) begin errors++; $display("FAIL idle_hit: got %0d want %0d", if_a.hit_cnt, exp_hit_a); end
    endtask

    task automatic test_pattern_change();
        step_a(1'b1, 8'h26);
        if_a.pattern[15:8] = 8'h77;
        step_a(1'b1, 8'h77);
        checks++; if (if_a.progress !== 2'd2) begin errors++; $display("FAIL patchg_progress: got %0d want 2", if_a.progress); end
        if_a.pattern = 24'h6ef526;
        step_a(1'b1, 8'h6e);
        exp_hit_a++;
        checks++; if (if_a.match !== 1'b1)    begin errors++; $display("FAIL patchg_match: got %b want 1", if_a.match); end
        checks++; if (if_a.hit_cnt !== 8'(exp_hit_a)) begin errors++; $display("FAIL patchg_hit: got %0d want %0d", if_a.hit_cnt, exp_hit_a); end
    endtask

    task automatic test_saturate();
        logic [1:0] e_h [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int n = 0; n < 5; n++) begin
            step_b(1'b1, 8'h26);
            checks++; if (if_b.match !== 1'b0) begin errors++; $display("FAIL sat_gap[%0d]: got %b want 0", n, if_b.match); end
            step_b(1'b1, 8'hf5);
            step_b(1'b1, 8'h6e);
            checks++; if (if_b.match !== 1'b1)    begin errors++; $display("FAIL sat_match[%0d]: got %b want 1", n, if_b.match); end
            checks++; if (if_b.hit_cnt !== e_h[n]) begin errors++; $display("FAIL sat_hit[%0d]: got %0d want %0d", n, if_b.hit_cnt, e_h[n]); end
        end
        checks++; if (if_b.found !== 1'b1) begin errors++; $display("FAIL sat_found: got %b want 1", if_b.found); end
        step_b(1'b1, 8'h26);
        step_b(1'b1, 8'hf5);
        if_b.clr = 1'b1;
        step_b(1'b1, 8'h6e);
        if_b.clr = 1'b0;
        checks++; if (if_b.match !== 1'b1)   begin errors++; $display("FAIL clr_match: got %b want 1", if_b.match); end
        checks++; if (if_b.hit_cnt !== 2'd0) begin errors++; $display("FAIL clr_hit: got %0d want 0", if_b.hit_cnt); end
        checks++; if (if_b.found !== 1'b0)   begin errors++; $display("FAIL clr_found: got %b want 0", if_b.found); end
        step_b(1'b0, 8'h00);
        checks++; if (if_b.match !== 1'b0)   begin errors++; $display("FAIL clr_after_match: got %b want 0", if_b.match); end
        checks++; if (if_b.found !== 1'b0)   begin errors++; $display("FAIL clr_after_found: got %b want 0", if_b.found); end
    endtask

    task automatic test_seq_len1();
        logic [7:0] d   [4] = '{8'ha5, 8'ha5, 8'h00, 8'ha5};
        logic       e_m [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step_c(1'b1, d[i]);
            checks++; if (if_c.match !== e_m[i])   begin errors++; $display("FAIL len1_match[%0d]: got %b want %b", i, if_c.match, e_m[i]); end
            checks++; if (if_c.progress !== 1'b0)  begin errors++; $display("FAIL len1_progress[%0d]: got %0d want 0", i, if_c.progress); end
        end
        checks++; if (if_c.hit_cnt !== 8'd3) begin errors++; $display("FAIL len1_hit: got %0d want 3", if_c.hit_cnt); end
        checks++; if (if_c.found !== 1'b1)   begin errors++; $display("FAIL len1_found: got %b want 1", if_c.found); end
    endtask

    task automatic test_reset_mid();
        step_a(1'b1, 8'h26);
        step_a(1'b1, 8'hf5);
        checks++; if (if_a.progress !== 2'd2) begin errors++; $display("FAIL rstmid_pre: got %0d want 2", if_a.progress); end
        checks++; if (if_a.found !== 1'b1)    begin errors++; $display("FAIL rstmid_found_pre: got %b want 1", if_a.found); end
        rst = 1'b1;
        step_a(1'b0, 8'h00);
        rst = 1'b0;
        checks++; if (if_a.progress !== 2'd0) begin errors++; $display("FAIL rstmid_progress: got %0d want 0", if_a.progress); end
        checks++; if (if_a.match !== 1'b0)    begin errors++; $display("FAIL rstmid_match: got %b want 0", if_a.match); end
        checks++; if (if_a.found !== 1'b0)    begin errors++; $display("FAIL rstmid_found: got %b want 0", if_a.found); end
        checks++; if (if_a.hit_cnt !== 8'd0)  begin errors++; $display("FAIL rstmid_hit: got %0d want 0", if_a.hit_cnt); end
        step_a(1'b1, 8'h6e);
        checks++; if (if_a.match !== 1'b0)    begin errors++; $display("FAIL rstmid_no_match: got %b want 0", if_a.match); end
        checks++; if (if_a.progress !== 2'd0) begin errors++; $display("FAIL rstmid_after: got %0d want 0", if_a.progress); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart();
        test_idle();
        test_pattern_change();
        test_saturate();
        test_seq_len1();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised successor of the fixed 3-byte sequence detector.
- Watches a byte stream qualified by a valid strobe for a programmable pattern of SEQ_LEN symbols, each DATA_W bits wide.
- Each complete detection produces a one-cycle match pulse, sets a sticky found flag and increments a saturating hit counter.
- Sits on the input stream as a trigger/monitor; its outputs feed downstream control and test-bench checkers.

Parameters:
DATA_W, 8, symbol width in bits
SEQ_LEN, 3, pattern length in symbols (>=1)
CNT_W, 8, hit counter width
TIMEOUT, 16, idle cycles before partial progress is dropped (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  in_data qualifier; when low, no symbol is consumed
in_data  in  DATA_W  input symbol
pattern  in  SEQ_LEN*DATA_W  pattern; symbol k at bits [k*DATA_W +: DATA_W], symbol 0 matched first
clr  in  1  clears found and hit_cnt
match  out  1  one-cycle pulse per completed detection
found  out  1  sticky; set on first detection
hit_cnt  out  CNT_W  detection count, saturating
progress  out  max(1,$clog2(SEQ_LEN))  number of symbols currently matched (0..SEQ_LEN-1)

Behaviour:
- Reset: progress=0, match=0, found=0, hit_cnt=0. Reset mid-sequence discards partial progress.
- State is progress s. It changes only on cycles with in_valid=1. With in_valid=0, s holds and match=0.
- Valid beat, priority order:
  - (a) in_data==pattern[s] and s==SEQ_LEN-1: match<=1 on the next cycle (latency 1); s<=0. Detection is non-overlapping.
  - (b) in_data==pattern[s] and s<SEQ_LEN-1: s<=s+1.
  - (c) mismatch and in_data==pattern[0]: s<=1, or s<=0 with a match pulse if SEQ_LEN==1 (that case cannot arise, since (a) already covers it).
  - (d) otherwise: s<=0.
- SEQ_LEN==1: every valid beat equal to pattern[0] pulses match; progress stays 0.
- match is registered and deasserts the cycle after it asserts unless another detection completes.
- found<=1 on any detection and stays set until clr or rst.
- hit_cnt increments by 1 per detection and saturates at 2^CNT_W-1 (no wrap).
- clr has priority over a simultaneous detection: found and hit_cnt go to 0, the match pulse is still produced, and progress is unaffected by clr.
- pattern is sampled combinationally each beat. Changing it mid-sequence is legal; comparison uses the new value against the current s.

Optional Feature:
- SEQ_DET_TIMEOUT_EN defined:
  - An idle counter counts consecutive cycles with in_valid=0 while s!=0.
  - When it reaches TIMEOUT, s<=0 on that edge. The counter clears on any valid beat or when s==0.
  - No match is produced by a timeout.
- Not defined: partial progress is held indefinitely; TIMEOUT is ignored and no idle counter is built.

Decomposition:
- Package seq_det_pkg holds:
  - progress-width function clog2_min1(n)
  - default DATA_W/SEQ_LEN/CNT_W constants
  - a localparam for the saturation value, computed from CNT_W.
- One sub-module is natural: sat_counter (parametrised width, inc, clr with priority, saturating). It is used for hit_cnt and, under SEQ_DET_TIMEOUT_EN, for the idle counter.

Test Plan:
- pattern=6e_f5_26 (symbol0=26), stream 26,f5,6e with valid each cycle -> progress 1,2,0; match=1 one cycle after the 6e beat; found=1; hit_cnt=1.
- Stream 26,26,f5,6e -> second 26 keeps progress=1 via rule (c); match pulses once; stream 26,f5,00,6e -> no match, progress 0 after 00.
- Stream 26, in_valid=0 for 5 cycles, then f5,6e -> match pulses (timeout disabled). With SEQ_DET_TIMEOUT_EN and TIMEOUT=4 -> progress drops to 0 after 4 idle cycles; no match.
- CNT_W=2, 5 back-to-back detections -> hit_cnt 1,2,3,3,3; clr asserted in the same cycle as the 6th detection -> hit_cnt=0, found=0, match=1.
- rst asserted while progress=2, then 6e -> no match; all outputs 0 the cycle after rst.
- SEQ_LEN=1, pattern=a5, stream a5,a5,00,a5 -> match high on 3 of the 4 following cycles; hit_cnt=3.
